uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver: samples the asynchronous RX line and delivers whole
//  characters as a 1-cycle valid strobe with a parity status flag.
//  Sits directly upstream of the console block (uart_io). Its uart_rx_d,
//  uart_rx_dv and parity_ok outputs connect 1:1 to the console block inputs.
//  There is no back-pressure: the consumer must accept every strobe.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency in Hz
//  BAUD_RATE  115_200      line rate in bit/s
//  NR_BITS    8            data bits per character, 5..8, sent LSB first
//  PARITY     0            0 = none, 1 = odd, 2 = even
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous reset, active high
//  rx           in   1        asynchronous serial line, idle high
//  uart_rx_d    out  NR_BITS  received character
//  uart_rx_dv   out  1        1-cycle strobe, uart_rx_d/parity_ok valid
//  parity_ok    out  1        1 = parity matched (always 1 when PARITY=0)
//  frame_error  out  1        1-cycle strobe, stop bit sampled low
//  rx_busy      out  1        high from start-bit detect until IDLE re-entered
// BEHAVIOUR
//  - Interface: one clock (clk); rst is synchronous and active high.
//  - Timing constants: BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division).
//    Elaboration $finish if BIT_CYCLES < 4, NR_BITS not in 5..8, or PARITY > 2.
//  - Synchronizer: rx passes through a 2-FF synchronizer (rx_s), reset to 1.
//    All decisions below use rx_s.
//  - Bit timer: down-counter of width clog2(BIT_CYCLES). A sample point is the
//    cycle on which the counter reads 0; the counter is then reloaded.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//  - IDLE: when rx_s==0, load counter with BIT_CYCLES/2-1 and go to START.
//  - START, sample point:
//      - rx_s==0: load BIT_CYCLES-1, clear bit index, go to DATA.
//      - rx_s==1: glitch; go to IDLE with no output.
//  - DATA: at each sample point, shift rx_s in at the MSB (LSB first on line).
//    After NR_BITS samples, go to PARITY if PARITY!=0, else to STOP.
//  - PARITY: at the sample point, capture the bit.
//      - odd: ok = ^{data,bit}==1
//      - even: ok = ^{data,bit}==0
//  - STOP, sample point (mid stop bit):
//      - rx_s==1: next cycle uart_rx_dv=1, uart_rx_d=data, parity_ok=result;
//        go to IDLE immediately, without waiting for the end of the stop bit,
//        so the next start edge is caught.
//      - rx_s==0: next cycle frame_error=1, no uart_rx_dv; go to BREAK.
//  - BREAK: stay until rx_s==1, then go to IDLE. This absorbs line breaks.
//  - Output holding: uart_rx_d and parity_ok hold their values between
//    strobes. uart_rx_dv and frame_error are high for exactly 1 cycle.
//  - Latency: uart_rx_dv rises 1 cycle after the mid-stop sample, i.e.
//    2 (sync) + BIT_CYCLES/2 + (NR_BITS + (PARITY?1:0) + 1)*BIT_CYCLES + 1
//    cycles after the rx falling edge, within ±1 cycle.
//  - Back-to-back characters with no idle time must be received without loss.
//  - Reset: rst wins over every other event, including mid-frame.
//      - Outputs: uart_rx_d=0, uart_rx_dv=0, parity_ok=0, frame_error=0,
//        rx_busy=0.
//      - Internal: FSM=IDLE, counter=0, shift register=0, sync FFs=1.
//      - A partial frame is discarded. Reception resumes at the next start
//        edge after rst drops, including one that occurs mid-frame.
// TESTING  (CLK_FREQ=1_600_000, BAUD_RATE=100_000 -> BIT_CYCLES=16, NR_BITS=8)
//  1. PARITY=2, send 0x41 with parity bit 0
//     -> one uart_rx_dv, uart_rx_d=0x41, parity_ok=1, frame_error never high.
//  2. PARITY=2, send 0x41 with parity bit 1
//     -> uart_rx_dv, uart_rx_d=0x41, parity_ok=0.
//     PARITY=1, same frame -> parity_ok=1.
//  3. rx low pulse of 5 cycles, then idle
//     -> no uart_rx_dv, no frame_error, rx_busy back to 0 by cycle 12.
//  4. rx held low for 20 bit times, then 0x0D
//     -> exactly one frame_error pulse, no uart_rx_dv for the break,
//        then uart_rx_dv with 0x0D.
//  5. PARITY=0, send 0x55,0xAA,0x0A back-to-back with one stop bit each
//     -> three strobes in order, with parity_ok=1 on each.
//  6. rst pulsed during bit 3 of 0x33, then 0x34 sent
//     -> no strobe for 0x33, all outputs 0 after the reset cycle,
//        one strobe with 0x34.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, mid-bit sampling with a reloading down-counter,
// delivers each character as a 1-cycle strobe with a parity status flag.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int NR_BITS   = 8,
    parameter int PARITY    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [NR_BITS-1:0] uart_rx_d,
    output logic               uart_rx_dv,
    output logic               parity_ok,
    output logic               frame_error,
    output logic               rx_busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W      = (NR_BITS > 1) ? $clog2(NR_BITS) : 1;

    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NR_BITS - 1);

    generate
        if (BIT_CYCLES < 4 || NR_BITS < 5 || NR_BITS > 8 || PARITY < 0 || PARITY > 2) begin : g_bad_params
            $fatal(1, "uart_rx: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]         sync_q;
    logic               rx_s;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NR_BITS-1:0] shift_q, shift_d;
    logic               par_ok_q, par_ok_d;
    logic [NR_BITS-1:0] data_q, data_d;
    logic               dv_q, dv_d;
    logic               pok_q, pok_d;
    logic               ferr_q, ferr_d;
    logic               tick;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_ok_q <= 1'b0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            pok_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_ok_q <= par_ok_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            pok_q    <= pok_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? FULL_RELOAD : (cnt_q - CNT_W'(1));
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_ok_d = par_ok_q;
        data_d   = data_q;
        dv_d     = 1'b0;
        pok_d    = pok_q;
        ferr_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[NR_BITS-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_ok_d = (PARITY == 1) ? (^{shift_q, rx_s}) : ~(^{shift_q, rx_s});
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (rx_s) begin
                        dv_d    = 1'b1;
                        data_d  = shift_q;
                        pok_d   = (PARITY == 0) ? 1'b1 : par_ok_q;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign uart_rx_d   = data_q;
    assign uart_rx_dv  = dv_q;
    assign parity_ok   = pok_q;
    assign frame_error = ferr_q;
    assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (no/odd/even parity) on separate lines, scoreboard
// queues filled by the frame generator and drained by an independent output monitor.
module tb_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BITC     = CLK_FREQ / BAUD;
    localparam int NB       = 8;
    localparam int NI       = 3;

    logic          clk;
    logic          rst;
    logic [NI-1:0] rx_r;
    logic [NB-1:0] d_o    [NI];
    logic          dv_o   [NI];
    logic          pok_o  [NI];
    logic          ferr_o [NI];
    logic          busy_o [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            uart_rx #(
                .CLK_FREQ (CLK_FREQ),
                .BAUD_RATE(BAUD),
                .NR_BITS  (NB),
                .PARITY   (gi)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .rx         (rx_r[gi]),
                .uart_rx_d  (d_o[gi]),
                .uart_rx_dv (dv_o[gi]),
                .parity_ok  (pok_o[gi]),
                .frame_error(ferr_o[gi]),
                .rx_busy    (busy_o[gi])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       pok;
        logic       ferr;
        int         due;
    } exp_t;

    exp_t sb[NI][$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference parity rule: 0 = none (always ok), 1 = odd, 2 = even total count of ones.
    function automatic logic model_pok(int mode, logic [7:0] d, logic pb);
        int ones = $countones(d) + int'(pb);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    function automatic int frame_latency(int inst);
        int nbits = NB + ((inst != 0) ? 1 : 0) + 1;
        return 2 + BITC / 2 + nbits * BITC + 1;
    endfunction

    task automatic bit_out(int inst, logic v);
        rx_r[inst] = v;
        repeat (BITC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(int inst, logic [7:0] d, logic pb, logic stop_b, int gap);
        exp_t e;
        e.data = d;
        e.pok  = model_pok(inst, d, pb);
        e.ferr = !stop_b;
        e.due  = cyc + frame_latency(inst);
        sb[inst].push_back(e);
        $display("send inst%0d data=%02h pbit=%0b stop=%0b gap=%0d", inst, d, pb, stop_b, gap);
        bit_out(inst, 1'b0);
        for (int i = 0; i < NB; i++) bit_out(inst, d[i]);
        if (inst != 0) bit_out(inst, pb);
        bit_out(inst, stop_b);
        rx_r[inst] = 1'b1;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_neg(int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_all_zero(string tag, int j);
        check($sformatf("%s_d_inst%0d", tag, j), 32'(d_o[j]), 0);
        check($sformatf("%s_dv_inst%0d", tag, j), 32'(dv_o[j]), 0);
        check($sformatf("%s_pok_inst%0d", tag, j), 32'(pok_o[j]), 0);
        check($sformatf("%s_ferr_inst%0d", tag, j), 32'(ferr_o[j]), 0);
        check($sformatf("%s_busy_inst%0d", tag, j), 32'(busy_o[j]), 0);
    endtask

    initial begin
        int t0;
        int budget;
        int inst;
        logic [7:0] d;
        logic pb;
        logic stop_b;
        int gap;
        logic [7:0] d33;

        rx_r = '1;
        rst  = 1'b1;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int j = 0; j < NI; j++) begin
                        if (dv_o[j] === 1'b1 || ferr_o[j] === 1'b1) begin
                            if (sb[j].size() == 0) begin
                                check($sformatf("unexpected_event_inst%0d", j), {30'd0, dv_o[j], ferr_o[j]}, 0);
                            end else begin
                                e = sb[j].pop_front();
                                $display("recv inst%0d dv=%0b ferr=%0b d=%02h pok=%0b cycle=%0d due=%0d",
                                         j, dv_o[j], ferr_o[j], d_o[j], pok_o[j], cyc, e.due);
                                check($sformatf("dv_inst%0d", j), 32'(dv_o[j]), 32'(!e.ferr));
                                check($sformatf("ferr_inst%0d", j), 32'(ferr_o[j]), 32'(e.ferr));
                                if (!e.ferr) begin
                                    check($sformatf("data_inst%0d", j), 32'(d_o[j]), 32'(e.data));
                                    check($sformatf("parity_ok_inst%0d", j), 32'(pok_o[j]), 32'(e.pok));
                                end
                                check($sformatf("latency_ok_inst%0d", j),
                                      32'((cyc >= e.due - 1) && (cyc <= e.due + 1)), 1);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < NI; j++) check_all_zero("reset", j);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Parity cases: even/ok, even/bad, odd/ok
        send_frame(2, 8'h41, 1'b0, 1'b1, 16);
        send_frame(2, 8'h41, 1'b1, 1'b1, 16);
        send_frame(1, 8'h41, 1'b1, 1'b1, 16);

        // Short glitch rejected, busy drops quickly
        t0 = cyc;
        rx_r[0] = 1'b0;
        wait_neg(t0 + 4);
        check("glitch_busy_high", 32'(busy_o[0]), 1);
        @(posedge clk);
        #1;
        rx_r[0] = 1'b1;
        wait_neg(t0 + 12);
        check("glitch_busy_low", 32'(busy_o[0]), 0);
        repeat (2 * BITC) @(posedge clk);
        #1;

        // Line break: a single frame error, then a normal character
        begin
            exp_t e;
            e.data = 8'h00;
            e.pok  = 1'b0;
            e.ferr = 1'b1;
            e.due  = cyc + frame_latency(0);
            sb[0].push_back(e);
            $display("send inst0 break 20 bit times");
            rx_r[0] = 1'b0;
            repeat (20 * BITC) @(posedge clk);
            #1;
            rx_r[0] = 1'b1;
            repeat (BITC) @(posedge clk);
            #1;
        end
        send_frame(0, 8'h0D, 1'b0, 1'b1, 16);

        // Back-to-back characters
        send_frame(0, 8'h55, 1'b0, 1'b1, 0);
        send_frame(0, 8'hAA, 1'b0, 1'b1, 0);
        send_frame(0, 8'h0A, 1'b0, 1'b1, 16);

        // Reset during bit 3 of 0x33 discards the frame
        d33 = 8'h33;
        $display("send inst0 data=33 aborted by reset in bit 3");
        bit_out(0, 1'b0);
        for (int i = 0; i < 3; i++) bit_out(0, d33[i]);
        rx_r[0] = d33[3];
        repeat (BITC / 2) @(posedge clk);
        #1;
        rst     = 1'b1;
        rx_r[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_rst", 0);
        repeat (2 * BITC) @(posedge clk);
        #1;
        send_frame(0, 8'h34, 1'b0, 1'b1, 16);

        // Randomised frames across all three parity modes
        for (int n = 0; n < 36; n++) begin
            inst   = int'($urandom_range(0, NI - 1));
            d      = 8'($urandom);
            pb     = 1'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            gap    = stop_b ? int'($urandom_range(0, 1) * $urandom_range(0, 40)) : 24;
            send_frame(inst, d, pb, stop_b, gap);
        end

        // Drain scoreboard with a bounded wait
        budget = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (2 * BITC) @(negedge clk);
        for (int j = 0; j < NI; j++) check($sformatf("drain_inst%0d", j), 32'(sb[j].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
